// File: rtl/term_cfg_pkg.sv
// Shared constants and helper functions for the terminal-tile configuration relay.
// Holds the select-width rule, the multi-hot strobe test and the legal-range checks.
package term_cfg_pkg;

    localparam int DEF_FRAME_BITS   = 32;
    localparam int DEF_MAX_FRAMES   = 20;
    localparam int DEF_PIPE_STAGES  = 1;
    localparam int DEF_LOCAL_FRAMES = 1;
    localparam int DEF_NUM_SRC      = 16;
    // Eight 4-bit selects are the most that fit in a single 32-bit local frame.
    localparam int DEF_CHANNELS     = 8;
    localparam int DEF_LOOP_REG     = 0;

    localparam int MAX_PIPE_STAGES  = 4;
    localparam int STROBE_MAX_W     = 64;

    function automatic int sel_width(input int num_src);
        return (num_src <= 2) ? 1 : $clog2(num_src);
    endfunction

    function automatic logic multi_hot(input logic [STROBE_MAX_W-1:0] vec);
        int count;
        count = 0;
        for (int i = 0; i < STROBE_MAX_W; i++) begin
            if (vec[i]) begin
                count++;
            end
        end
        return count >= 2;
    endfunction

    function automatic bit pipe_stages_legal(input int stages);
        return (stages >= 0) && (stages <= MAX_PIPE_STAGES);
    endfunction

    function automatic bit local_frames_legal(input int frames, input int max_frames);
        return (frames >= 1) && (frames <= max_frames);
    endfunction

    function automatic bit crossbar_fits(input int channels, input int sel_w, input int cfg_w);
        return (channels * sel_w) <= cfg_w;
    endfunction

    function automatic bit strobe_width_legal(input int max_frames);
        return (max_frames >= 1) && (max_frames <= STROBE_MAX_W);
    endfunction

endpackage

// File: rtl/cfg_pipe.sv
// N-stage register delay line with synchronous clear, used on the configuration chain.
// Always has at least one stage; the zero-stage case is a plain wire in the parent.
module cfg_pipe
    import term_cfg_pkg::*;
#(
    parameter int WIDTH  = DEF_FRAME_BITS,
    parameter int STAGES = DEF_PIPE_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] stage_d;
    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/term_config_relay.sv
// Terminal tile: relays the config chain with optional pipelining, captures local
// frames on strobe rising edges, and loops END wires back to BEG wires via a crossbar.
module term_config_relay
    import term_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = DEF_FRAME_BITS,
    parameter int MaxFramesPerCol = DEF_MAX_FRAMES,
    parameter int PIPE_STAGES     = DEF_PIPE_STAGES,
    parameter int LOCAL_FRAMES    = DEF_LOCAL_FRAMES,
    parameter int NUM_SRC         = DEF_NUM_SRC,
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int LOOP_REG        = DEF_LOOP_REG
) (
    input  logic                                   UserCLK,
    input  logic                                   Reset,
    output logic                                   UserCLKo,
    input  logic [FrameBitsPerRow-1:0]             FrameData,
    output logic [FrameBitsPerRow-1:0]             FrameData_O,
    input  logic [MaxFramesPerCol-1:0]             FrameStrobe,
    output logic [MaxFramesPerCol-1:0]             FrameStrobe_O,
    input  logic [NUM_SRC-1:0]                     S_END,
    output logic [CHANNELS-1:0]                    N_BEG,
    output logic                                   StrobeErr,
    output logic [LOCAL_FRAMES*FrameBitsPerRow-1:0] CfgBits
);

    localparam int SEL_W     = sel_width(NUM_SRC);
    localparam int CFG_W     = LOCAL_FRAMES * FrameBitsPerRow;
    localparam int SRC_PAD_W = 1 << SEL_W;

    if (!pipe_stages_legal(PIPE_STAGES)) begin : g_bad_pipe
        $error("term_config_relay: PIPE_STAGES must be in 0..4");
    end
    if (!local_frames_legal(LOCAL_FRAMES, MaxFramesPerCol)) begin : g_bad_frames
        $error("term_config_relay: LOCAL_FRAMES must be in 1..MaxFramesPerCol");
    end
    if (!crossbar_fits(CHANNELS, SEL_W, CFG_W)) begin : g_bad_xbar
        $error("term_config_relay: CHANNELS*SEL_W exceeds captured configuration width");
    end
    if (!strobe_width_legal(MaxFramesPerCol)) begin : g_bad_strobe
        $error("term_config_relay: MaxFramesPerCol out of supported range");
    end

    assign UserCLKo = UserCLK;

    if (PIPE_STAGES == 0) begin : g_relay_wire
        assign FrameData_O   = FrameData;
        assign FrameStrobe_O = FrameStrobe;
    end else begin : g_relay_pipe
        cfg_pipe #(
            .WIDTH  (FrameBitsPerRow),
            .STAGES (PIPE_STAGES)
        ) u_data_pipe (
            .clk  (UserCLK),
            .rst  (Reset),
            .din  (FrameData),
            .dout (FrameData_O)
        );

        cfg_pipe #(
            .WIDTH  (MaxFramesPerCol),
            .STAGES (PIPE_STAGES)
        ) u_strobe_pipe (
            .clk  (UserCLK),
            .rst  (Reset),
            .din  (FrameStrobe),
            .dout (FrameStrobe_O)
        );
    end

    logic [LOCAL_FRAMES-1:0]                      strb_d;
    logic [LOCAL_FRAMES-1:0]                      strb_q;
    logic                                         strb_valid_d;
    logic                                         strb_valid_q;
    logic [LOCAL_FRAMES-1:0]                      rise;
    logic [LOCAL_FRAMES-1:0][FrameBitsPerRow-1:0] cfg_d;
    logic [LOCAL_FRAMES-1:0][FrameBitsPerRow-1:0] cfg_q;
    logic [STROBE_MAX_W-1:0]                      strobe_ext;
    logic                                         err_d;
    logic                                         err_q;

    // strb_valid_q stays low for the first cycle after reset, so a strobe that is
    // already high when reset releases is not mistaken for a rising edge.
    always_comb begin
        strb_d       = FrameStrobe[LOCAL_FRAMES-1:0];
        strb_valid_d = 1'b1;
        rise         = strb_valid_q ? (FrameStrobe[LOCAL_FRAMES-1:0] & ~strb_q) : '0;
        cfg_d        = cfg_q;
        for (int f = 0; f < LOCAL_FRAMES; f++) begin
            if (rise[f]) begin
                cfg_d[f] = FrameData;
            end
        end
        strobe_ext                        = '0;
        strobe_ext[MaxFramesPerCol-1:0]   = FrameStrobe;
        err_d                             = err_q | multi_hot(strobe_ext);
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            strb_q       <= '0;
            strb_valid_q <= 1'b0;
            cfg_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            strb_q       <= strb_d;
            strb_valid_q <= strb_valid_d;
            cfg_q        <= cfg_d;
            err_q        <= err_d;
        end
    end

    assign CfgBits   = cfg_q;
    assign StrobeErr = err_q;

    logic [SRC_PAD_W-1:0] src_pad;
    logic [CHANNELS-1:0]  xbar;

    // Sources are zero-padded to a power of two so out-of-range selects read 0.
    always_comb begin
        src_pad              = '0;
        src_pad[NUM_SRC-1:0] = S_END;
        xbar                 = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            xbar[c] = src_pad[CfgBits[c*SEL_W +: SEL_W]];
        end
    end

    if (LOOP_REG != 0) begin : g_loop_reg
        logic [CHANNELS-1:0] nbeg_d;
        logic [CHANNELS-1:0] nbeg_q;

        always_comb begin
            nbeg_d = xbar;
        end

        always_ff @(posedge UserCLK) begin
            if (Reset) begin
                nbeg_q <= '0;
            end else begin
                nbeg_q <= nbeg_d;
            end
        end

        assign N_BEG = nbeg_q;
    end else begin : g_loop_comb
        assign N_BEG = xbar;
    end

endmodule

// File: tb/tb_term_config_relay.sv
// Directed bench for term_config_relay: two instances (pipelined/comb-loopback and
// wire-relay/registered-loopback) share stimulus and are checked against hand values.
module tb_term_config_relay;

    logic        UserCLK;
    logic        Reset;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic [15:0] S_END;

    logic        a_clko;
    logic [31:0] a_data_o;
    logic [19:0] a_strobe_o;
    logic [15:0] a_n_beg;
    logic        a_err;
    logic [63:0] a_cfg;

    logic        b_clko;
    logic [31:0] b_data_o;
    logic [19:0] b_strobe_o;
    logic [7:0]  b_n_beg;
    logic        b_err;
    logic [31:0] b_cfg;

    int check_count;
    int error_count;

    term_config_relay #(
        .FrameBitsPerRow (32),
        .MaxFramesPerCol (20),
        .PIPE_STAGES     (2),
        .LOCAL_FRAMES    (2),
        .NUM_SRC         (16),
        .CHANNELS        (16),
        .LOOP_REG        (0)
    ) dut_a (
        .UserCLK       (UserCLK),
        .Reset         (Reset),
        .UserCLKo      (a_clko),
        .FrameData     (FrameData),
        .FrameData_O   (a_data_o),
        .FrameStrobe   (FrameStrobe),
        .FrameStrobe_O (a_strobe_o),
        .S_END         (S_END),
        .N_BEG         (a_n_beg),
        .StrobeErr     (a_err),
        .CfgBits       (a_cfg)
    );

    term_config_relay #(
        .FrameBitsPerRow (32),
        .MaxFramesPerCol (20),
        .PIPE_STAGES     (0),
        .LOCAL_FRAMES    (1),
        .NUM_SRC         (16),
        .CHANNELS        (8),
        .LOOP_REG        (1)
    ) dut_b (
        .UserCLK       (UserCLK),
        .Reset         (Reset),
        .UserCLKo      (b_clko),
        .FrameData     (FrameData),
        .FrameData_O   (b_data_o),
        .FrameStrobe   (FrameStrobe),
        .FrameStrobe_O (b_strobe_o),
        .S_END         (S_END),
        .N_BEG         (b_n_beg),
        .StrobeErr     (b_err),
        .CfgBits       (b_cfg)
    );

    initial begin
        UserCLK = 1'b0;
        forever #5 UserCLK = ~UserCLK;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] data,
                                 input logic [19:0] strobe, input logic [15:0] src);
        Reset       = rst;
        FrameData   = data;
        FrameStrobe = strobe;
        S_END       = src;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge UserCLK);
        #1;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;

        applyStimulus(1'b1, 32'h0, 20'h0, 16'h0);
        nextCycle();
        nextCycle();
        checkOutput("reset a_data_o", 64'(a_data_o), 64'h0);
        checkOutput("reset a_strobe_o", 64'(a_strobe_o), 64'h0);
        checkOutput("reset a_err", 64'(a_err), 64'h0);
        checkOutput("reset a_cfg", a_cfg, 64'h0);
        checkOutput("reset b_cfg", 64'(b_cfg), 64'h0);
        checkOutput("reset b_n_beg", 64'(b_n_beg), 64'h0);
        checkOutput("reset a_n_beg", 64'(a_n_beg), 64'h0);
        checkOutput("clko high", 64'(a_clko), 64'h1);
        @(negedge UserCLK);
        #1;
        checkOutput("clko low", 64'(b_clko), 64'h0);

        applyStimulus(1'b0, 32'h0, 20'h0, 16'h0);
        nextCycle();

        // Relay latency: wire instance is same-cycle, pipelined one is two cycles late.
        applyStimulus(1'b0, 32'hA5A5_0001, 20'h00001, 16'h0);
        checkOutput("relay b data same cycle", 64'(b_data_o), 64'hA5A5_0001);
        checkOutput("relay b strobe same cycle", 64'(b_strobe_o), 64'h1);
        checkOutput("relay a data early", 64'(a_data_o), 64'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 20'h0, 16'h0);
        checkOutput("relay a data cycle1", 64'(a_data_o), 64'h0);
        checkOutput("relay b data gone", 64'(b_data_o), 64'h0);
        nextCycle();
        checkOutput("relay a data cycle2", 64'(a_data_o), 64'hA5A5_0001);
        checkOutput("relay a strobe cycle2", 64'(a_strobe_o), 64'h1);
        nextCycle();
        checkOutput("relay a data cycle3", 64'(a_data_o), 64'h0);
        checkOutput("relay a strobe cycle3", 64'(a_strobe_o), 64'h0);

        // Capture and loopback.
        applyStimulus(1'b0, 32'h0000_0003, 20'h00001, 16'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 20'h0, 16'h0008);
        checkOutput("capture a_cfg", a_cfg, 64'h3);
        checkOutput("capture b_cfg", 64'(b_cfg), 64'h3);
        checkOutput("loop a_n_beg", 64'(a_n_beg), 64'h0001);
        nextCycle();
        checkOutput("loop b_n_beg", 64'(b_n_beg), 64'h01);
        applyStimulus(1'b0, 32'h0, 20'h0, 16'h0009);
        checkOutput("loop a_n_beg comb", 64'(a_n_beg), 64'hFFFF);
        checkOutput("loop b_n_beg held", 64'(b_n_beg), 64'h01);
        nextCycle();
        checkOutput("loop b_n_beg reg", 64'(b_n_beg), 64'hFF);

        // Held strobe captures once; a fresh edge captures again.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 32'(k), 20'h00001, 16'h0009);
            nextCycle();
        end
        checkOutput("held a_cfg", a_cfg, 64'h1);
        checkOutput("held b_cfg", 64'(b_cfg), 64'h1);
        applyStimulus(1'b0, 32'h5, 20'h0, 16'h0009);
        nextCycle();
        applyStimulus(1'b0, 32'h7, 20'h00001, 16'h0009);
        nextCycle();
        checkOutput("recapture a_cfg", a_cfg, 64'h7);
        checkOutput("recapture b_cfg", 64'(b_cfg), 64'h7);
        applyStimulus(1'b0, 32'h0, 20'h0, 16'h0009);
        nextCycle();

        // Multi-hot strobe: sticky error, both local frames load the same data.
        checkOutput("err clear before", 64'(a_err), 64'h0);
        applyStimulus(1'b0, 32'h1234_5678, 20'h00003, 16'h0009);
        checkOutput("err not early", 64'(a_err), 64'h0);
        nextCycle();
        checkOutput("err a set", 64'(a_err), 64'h1);
        checkOutput("err b set", 64'(b_err), 64'h1);
        checkOutput("dual capture a_cfg", a_cfg, 64'h1234_5678_1234_5678);
        checkOutput("dual capture b_cfg", 64'(b_cfg), 64'h1234_5678);
        applyStimulus(1'b0, 32'h0, 20'h0, 16'h0009);
        nextCycle();
        checkOutput("err sticky", 64'(a_err), 64'h1);
        applyStimulus(1'b1, 32'h0, 20'h0, 16'h0009);
        nextCycle();
        checkOutput("err a reset", 64'(a_err), 64'h0);
        checkOutput("err b reset", 64'(b_err), 64'h0);
        checkOutput("reset2 a_cfg", a_cfg, 64'h0);
        checkOutput("reset2 b_cfg", 64'(b_cfg), 64'h0);
        checkOutput("reset2 b_n_beg", 64'(b_n_beg), 64'h0);
        checkOutput("reset2 a_n_beg follows src0", 64'(a_n_beg), 64'hFFFF);

        // Reset clears pipeline stages; non-local strobe bits are never captured.
        applyStimulus(1'b1, 32'h0, 20'h00004, 16'h0);
        checkOutput("wire relay during reset", 64'(b_strobe_o), 64'h4);
        nextCycle();
        checkOutput("pipe during reset", 64'(a_strobe_o), 64'h0);
        applyStimulus(1'b0, 32'h0, 20'h00004, 16'h0);
        nextCycle();
        checkOutput("pipe after release 1", 64'(a_strobe_o), 64'h0);
        nextCycle();
        checkOutput("pipe after release 2", 64'(a_strobe_o), 64'h4);
        checkOutput("nonlocal no capture", a_cfg, 64'h0);
        checkOutput("single hot no err", 64'(a_err), 64'h0);
        applyStimulus(1'b0, 32'h0, 20'h0, 16'h0);
        nextCycle();

        // Reset coinciding with a strobe rise, strobe still high afterwards.
        applyStimulus(1'b1, 32'hFFFF_FFFF, 20'h00001, 16'h0);
        nextCycle();
        checkOutput("reset wins a_cfg", a_cfg, 64'h0);
        checkOutput("reset wins b_cfg", 64'(b_cfg), 64'h0);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 20'h00001, 16'h0);
        nextCycle();
        checkOutput("held after reset a_cfg", a_cfg, 64'h0);
        checkOutput("held after reset b_cfg", 64'(b_cfg), 64'h0);
        nextCycle();
        checkOutput("held after reset 2", a_cfg, 64'h0);
        applyStimulus(1'b0, 32'h0, 20'h0, 16'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0000_0055, 20'h00001, 16'h0);
        nextCycle();
        checkOutput("post reset capture a_cfg", a_cfg, 64'h55);
        checkOutput("post reset capture b_cfg", 64'(b_cfg), 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
